// File: rtl/caliptra_prim_edn_seed_buf_pkg.sv
// Shared types and limits for the EDN seed prefetch buffer.
package caliptra_prim_edn_seed_buf_pkg;

   localparam int unsigned MaxDepth = 8;

   // Sparse encoding: each state differs from the others in two bits.
   typedef enum logic [2:0] {
      StIdle  = 3'b001,
      StReq   = 3'b010,
      StDrain = 3'b100
   } seed_buf_state_e;

   function automatic logic state_requests(input seed_buf_state_e st);
      return (st == StReq) || (st == StDrain);
   endfunction

endpackage

// File: rtl/caliptra_prim_edn_seed_buf_store.sv
// In-order circular seed store with push, pop, clear, fill level and head output.
module caliptra_prim_edn_seed_buf_store
   import caliptra_prim_edn_seed_buf_pkg::*;
#(
   parameter  int unsigned SeedW = 128,
   parameter  int unsigned Depth = 2,
   localparam int unsigned EntW  = SeedW + 1,
   localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned LvlW  = $clog2(Depth + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            i_clr,
   input  logic            i_push,
   input  logic [EntW-1:0] i_wdata,
   input  logic            i_pop,
   output logic            o_valid,
   output logic [EntW-1:0] o_head,
   output logic [LvlW-1:0] o_level
);

   if (Depth < 1 || Depth > MaxDepth) begin : g_bad_depth
      $error("Depth must lie in 1..MaxDepth");
   end

   logic [EntW-1:0] r_mem [Depth];
   logic [PtrW-1:0] r_wptr;
   logic [PtrW-1:0] r_rptr;
   logic [LvlW-1:0] r_level;
   logic            w_do_push;
   logic            w_do_pop;

   // Explicit wrap keeps non-power-of-2 depths inside the array.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      if (p == PtrW'(Depth - 1)) begin
         return {PtrW{1'b0}};
      end else begin
         return p + PtrW'(1'b1);
      end
   endfunction

   assign w_do_push = i_push && (r_level != LvlW'(Depth));
   assign w_do_pop  = i_pop && (r_level != {LvlW{1'b0}});

   // Seed storage; contents past the level are don't-care after a clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(Depth); i++) begin
            r_mem[i] <= {EntW{1'b0}};
         end
      end else if (!i_clr && w_do_push) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   // Pointers and fill level; clear wins over push and pop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr  <= {PtrW{1'b0}};
         r_rptr  <= {PtrW{1'b0}};
         r_level <= {LvlW{1'b0}};
      end else if (i_clr) begin
         r_wptr  <= {PtrW{1'b0}};
         r_rptr  <= {PtrW{1'b0}};
         r_level <= {LvlW{1'b0}};
      end else begin
         if (w_do_push) begin
            r_wptr <= ptr_inc(r_wptr);
         end
         if (w_do_pop) begin
            r_rptr <= ptr_inc(r_rptr);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + LvlW'(1'b1);
            2'b01:   r_level <= r_level - LvlW'(1'b1);
            default: r_level <= r_level;
         endcase
      end
   end

   assign o_valid = (r_level != {LvlW{1'b0}});
   assign o_head  = o_valid ? r_mem[r_rptr] : {EntW{1'b0}};
   assign o_level = r_level;

endmodule

// File: rtl/caliptra_prim_edn_seed_buf.sv
// Prefetching EDN seed buffer: request FSM, discard counter and seed store.
// Define CALIPTRA_EDN_SEED_BUF_FIPS_ONLY_EN to discard non-FIPS seeds.
module caliptra_prim_edn_seed_buf
   import caliptra_prim_edn_seed_buf_pkg::*;
#(
   parameter  int unsigned SeedW   = 128,
   parameter  int unsigned Depth   = 2,
   parameter  int unsigned ErrCntW = 8,
   localparam int unsigned LvlW    = $clog2(Depth + 1)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               en_i,
   input  logic               clr_i,
   output logic               edn_req_o,
   input  logic               edn_ack_i,
   input  logic [SeedW-1:0]   edn_data_i,
   input  logic               edn_fips_i,
   input  logic               edn_err_i,
   output logic               seed_valid_o,
   input  logic               seed_ready_i,
   output logic [SeedW-1:0]   seed_o,
   output logic               seed_fips_o,
   output logic [LvlW-1:0]    level_o,
   output logic               err_o,
   output logic [ErrCntW-1:0] err_cnt_o
);

   seed_buf_state_e    r_state;
   seed_buf_state_e    w_state_nxt;
   logic               r_err;
   logic [ErrCntW-1:0] r_err_cnt;
   logic               w_accept;
   logic               w_push;
   logic               w_discard;
   logic               w_pop;
   logic [SeedW:0]     w_head;
   logic [LvlW-1:0]    w_level;

`ifdef CALIPTRA_EDN_SEED_BUF_FIPS_ONLY_EN
   assign w_accept = !edn_err_i && edn_fips_i;
`else
   assign w_accept = !edn_err_i;
`endif

   assign w_push    = (r_state == StReq) && edn_ack_i && w_accept;
   assign w_discard = (r_state == StReq) && edn_ack_i && !w_accept;
   assign w_pop     = seed_valid_o && seed_ready_i;

   // Next state; an ack coinciding with a clear ends the request directly.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle: begin
            if (en_i && (w_level < LvlW'(Depth)) && !clr_i) begin
               w_state_nxt = StReq;
            end else begin
               w_state_nxt = StIdle;
            end
         end
         StReq: begin
            if (edn_ack_i) begin
               w_state_nxt = StIdle;
            end else if (clr_i) begin
               w_state_nxt = StDrain;
            end else begin
               w_state_nxt = StReq;
            end
         end
         StDrain: begin
            if (edn_ack_i) begin
               w_state_nxt = StIdle;
            end else begin
               w_state_nxt = StDrain;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Sticky discard flag and saturating counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_err     <= 1'b0;
         r_err_cnt <= {ErrCntW{1'b0}};
      end else if (clr_i) begin
         r_err     <= 1'b0;
         r_err_cnt <= {ErrCntW{1'b0}};
      end else if (w_discard) begin
         r_err <= 1'b1;
         if (r_err_cnt != {ErrCntW{1'b1}}) begin
            r_err_cnt <= r_err_cnt + ErrCntW'(1'b1);
         end
      end
   end

   caliptra_prim_edn_seed_buf_store #(
      .SeedW (SeedW),
      .Depth (Depth)
   ) u_store (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_clr   (clr_i),
      .i_push  (w_push),
      .i_wdata ({edn_fips_i, edn_data_i}),
      .i_pop   (w_pop),
      .o_valid (seed_valid_o),
      .o_head  (w_head),
      .o_level (w_level)
   );

   assign edn_req_o = state_requests(r_state);
   assign seed_o    = w_head[SeedW-1:0];
   assign level_o   = w_level;
   assign err_o     = r_err;
   assign err_cnt_o = r_err_cnt;

`ifdef CALIPTRA_EDN_SEED_BUF_FIPS_ONLY_EN
   logic w_unused_fips;
   assign w_unused_fips = w_head[SeedW];
   assign seed_fips_o   = 1'b1;
`else
   assign seed_fips_o   = w_head[SeedW];
`endif

endmodule

// File: doc/caliptra_prim_edn_seed_buf.md
# caliptra_prim_edn_seed_buf

Prefetching seed buffer that sits directly downstream of the EDN request gadget (`caliptra_prim_edn_req`) in the consumer clock domain. It keeps up to `Depth` packed `SeedW`-bit seeds ready for a local consumer such as a masking PRNG or DRBG reseed path. Whenever a slot is free it issues EDN requests using req/ack semantics. It discards seeds flagged by the repetition check and presents stored seeds through a valid/ready interface, each with its FIPS flag.

## Interface
- `SeedW`, 128: seed width; equals `OutWidth` of the upstream gadget.
- `Depth`, 2: number of buffered seeds; legal range 1..8.
- `ErrCntW`, 8: width of the saturating discard counter.

Clock and reset: **reset rst_ni, asynchronous, active-low; clock clk_i.**

- `clk_i`  in  1  consumer clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `en_i`  in  1  allow new EDN requests; an outstanding request always completes.
- `clr_i`  in  1  one-cycle pulse; flush stored seeds, clear `err_o` and `err_cnt_o`.
- `edn_req_o`  out  1  to gadget `req_i`.
- `edn_ack_i`  in  1  from gadget `ack_o`.
- `edn_data_i`  in  SeedW  from gadget `data_o`; valid only when `edn_ack_i`=1.
- `edn_fips_i`  in  1  from gadget `fips_o`.
- `edn_err_i`  in  1  from gadget `err_o`.
- `seed_valid_o`  out  1  head seed available.
- `seed_ready_i`  in  1  consumer accepts the head seed.
- `seed_o`  out  SeedW  head seed.
- `seed_fips_o`  out  1  FIPS flag of the head seed.
- `level_o`  out  $clog2(Depth+1)  number of stored seeds.
- `err_o`  out  1  sticky: at least one seed was discarded.
- `err_cnt_o`  out  ErrCntW  saturating count of discarded seeds.

## Operation

States are `IDLE`, `REQ` and `DRAIN`.

**IDLE**
- Go to `REQ` when `en_i` && `level_o` < `Depth` && !`clr_i`.

**REQ**
- `edn_req_o` = 1.
- `edn_req_o` stays high until `edn_ack_i`; it is never withdrawn early, as upstream protocol requires.
- On `edn_ack_i`:
  - Accept the seed if !`edn_err_i` (and FIPS filter passes, see Configuration). Push {`edn_fips_i`, `edn_data_i`}.
  - Otherwise discard it: set `err_o`, increment `err_cnt_o` (saturating at all-ones).
  - Next state is `IDLE`. Any required re-request starts from `IDLE`.
- `clr_i` while in `REQ`: go to `DRAIN`.

**DRAIN**
- `edn_req_o` = 1 until `edn_ack_i`.
- Returned data is dropped and not counted.
- Then go to `IDLE`.

**Storage and counters**
- Storage is in-order. Only one request is outstanding at a time, and a request is issued only when a slot is free, so a push never meets a full buffer.
- A pop occurs on `seed_valid_o` && `seed_ready_i`.
- Push and pop in the same cycle leave `level_o` unchanged.
- `clr_i` empties the storage and resets the read/write pointers.
- `clr_i` takes priority over a same-cycle push or pop, and over a same-cycle error increment.
- Read and write pointers wrap modulo `Depth`. Non-power-of-2 `Depth` is supported.
- Deasserting `en_i` stops new requests only.

## Timing
- **Reset values:**
  - `edn_req_o`=0, `seed_valid_o`=0, `seed_o`=0, `seed_fips_o`=0
  - `level_o`=0, `err_o`=0, `err_cnt_o`=0
  - state = `IDLE`
- **Request start:** `en_i` sampled high in cycle N gives `edn_req_o`=1 in cycle N+1. `edn_req_o` is decoded from the state register.
- **Ack to output:** ack in cycle N writes the seed at the end of N. `seed_valid_o` and `level_o` update in cycle N+1.
- **Output stability:** `seed_o` and `seed_fips_o` are registered/storage outputs and stay stable while `seed_valid_o` && !`seed_ready_i`.
- **Request gap:** `edn_req_o` is low for at least one cycle after every ack (the `REQ`→`IDLE`→`REQ` path).
- **Refill:** begins the cycle after a pop frees a slot (full→not full), when `en_i`=1.
- **Reset during `REQ`:** handled by the joint consumer-domain reset of the gadget; no extra handling is required.

## Configuration
- Macro: `CALIPTRA_EDN_SEED_BUF_FIPS_ONLY_EN`.
- **Defined:** a seed with `edn_fips_i`=0 is discarded and counted exactly like a repetition error. `seed_fips_o` is tied to 1.
- **Undefined:** non-FIPS seeds are stored, and `seed_fips_o` reports the stored flag.

## Structure
- Package `caliptra_prim_edn_seed_buf_pkg`:
  - state enum `seed_buf_state_e`, with sparse encoding and a default branch to `IDLE`
  - `MaxDepth` = 8 constant
- One sub-module, `caliptra_prim_edn_seed_buf_store`: a `Depth`×(`SeedW`+1) circular buffer with push, pop, clear, level, and head output.
- The FSM and error counter live in the top module.

## Test plan
- **Prefetch:** reset, `en_i`=1, `Depth`=2, ack after 5 cycles with data `0x1111…` then `0x2222…`
  - → `level_o` reaches 2
  - → `edn_req_o` stays 0 afterwards
  - → pops return the seeds in order.
- **Repetition discard:** ack with `edn_err_i`=1
  - → `level_o` unchanged, `err_o`=1, `err_cnt_o`=1
  - → `edn_req_o` reasserts 2 cycles later.
- **Clear during request:** `clr_i` pulsed while in `REQ`
  - → `edn_req_o` stays 1 until ack
  - → data is dropped, `level_o`=0, `err_cnt_o`=0
  - → a new request follows if `en_i` is high.
- **Push/pop collision:** simultaneous ack and pop at `level_o`=1
  - → `level_o` stays 1
  - → new seed is at the head next cycle.
- **Counter saturation:** 300 erroneous acks with `ErrCntW`=8 → `err_cnt_o`=255.
- **FIPS filter:** ack with `edn_fips_i`=0
  - → stored with `seed_fips_o`=0 without the macro
  - → discarded and `err_cnt_o` incremented with `CALIPTRA_EDN_SEED_BUF_FIPS_ONLY_EN`.
